// File: rtl/main_fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// main_fifo_reader_pkg
//   Shared definitions for the main FIFO reader: controller state encoding
//   and the default word geometry (word width and VC-select bit position).
// -----------------------------------------------------------------------------
package main_fifo_reader_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_STALL  = 2'd3
   } state_t;

   localparam int DEFAULT_DATA_WIDTH  = 6;
   localparam int DEFAULT_CLASS_BIT   = 5;
   localparam int DEFAULT_COUNT_WIDTH = 8;

endpackage : main_fifo_reader_pkg

// File: rtl/main_fifo_reader.sv
// -----------------------------------------------------------------------------
// main_fifo_reader
//   Consumer end of the main transmit FIFO. Pops a word whenever the FIFO is
//   non-empty and neither VC FIFO is almost full, then two cycles later pushes
//   it into VC0 or VC1 according to main_data[class_bit]. Keeps per-VC push
//   counters and a sticky overflow error for words dropped on a full VC.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   init             active-low soft hold (synchronous clear of counters/error)
//   main_empty       main FIFO empty flag
//   main_data        main FIFO read data, valid one cycle after a pop
//   main_rd_enable   pop request to the main FIFO (combinational)
//   vc0/1_almost_full  VC almost-full flags (>= 2 free entries when set)
//   vc0/1_full       VC full flags, checked at the push edge
//   vc_data          registered word presented to both VCs
//   vc0/1_wr_enable  single-cycle push strobes
//   vc0/1_count      words pushed to each VC, wraps modulo 2^count_width
//   error            sticky overflow (word dropped on a full VC)
//   idle             IDLE state with nothing in flight
// -----------------------------------------------------------------------------
module main_fifo_reader
   import main_fifo_reader_pkg::*;
#(
   parameter int data_width  = DEFAULT_DATA_WIDTH,
   parameter int class_bit   = DEFAULT_CLASS_BIT,
   parameter int count_width = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   init,
   input  logic                   main_empty,
   input  logic [data_width-1:0]  main_data,
   output logic                   main_rd_enable,
   input  logic                   vc0_almost_full,
   input  logic                   vc1_almost_full,
   input  logic                   vc0_full,
   input  logic                   vc1_full,
   output logic [data_width-1:0]  vc_data,
   output logic                   vc0_wr_enable,
   output logic                   vc1_wr_enable,
   output logic [count_width-1:0] vc0_count,
   output logic [count_width-1:0] vc1_count,
   output logic                   error,
   output logic                   idle
);

   state_t                 state_q,      state_d;
   logic                   rd_pending_q, rd_pending_d;
   logic [data_width-1:0]  vc_data_q,    vc_data_d;
   logic                   vc0_wr_q,     vc0_wr_d;
   logic                   vc1_wr_q,     vc1_wr_d;
   logic [count_width-1:0] vc0_count_q,  vc0_count_d;
   logic [count_width-1:0] vc1_count_q,  vc1_count_d;
   logic                   error_q,      error_d;

   logic any_almost_full;

   assign any_almost_full = vc0_almost_full | vc1_almost_full;

   // The destination is unknown until the word returns, so both almost-full
   // flags gate every pop; the 2-entry margin absorbs the word in flight.
   assign main_rd_enable = init && (state_q != ST_INIT) && !main_empty && !any_almost_full;

   // NOTE: every signal assigned here gets a default first, otherwise a path
   // that skips an assignment infers a latch.
   always_comb begin
      state_d      = state_q;
      rd_pending_d = main_rd_enable;
      vc_data_d    = vc_data_q;
      vc0_wr_d     = 1'b0;
      vc1_wr_d     = 1'b0;
      vc0_count_d  = vc0_count_q;
      vc1_count_d  = vc1_count_q;
      error_d      = error_q;

      unique case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (!main_empty) state_d = any_almost_full ? ST_STALL : ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_almost_full) state_d = ST_STALL;
            else if (main_empty) state_d = ST_IDLE;
         end
         ST_STALL: begin
            if (!any_almost_full) state_d = main_empty ? ST_IDLE : ST_ACTIVE;
         end
      endcase

      // Push stage: the word popped last cycle is now on main_data. vc_data
      // only changes when a push actually happens, so a dropped word leaves
      // the previous pushed value in place.
      if (rd_pending_q) begin
         if (main_data[class_bit]) begin
            if (vc1_full) begin
               error_d = 1'b1;
            end else begin
               vc_data_d   = main_data;
               vc1_wr_d    = 1'b1;
               vc1_count_d = vc1_count_q + count_width'(1);
            end
         end else begin
            if (vc0_full) begin
               error_d = 1'b1;
            end else begin
               vc_data_d   = main_data;
               vc0_wr_d    = 1'b1;
               vc0_count_d = vc0_count_q + count_width'(1);
            end
         end
      end

      // Soft hold overrides everything: discard the in-flight word and clear
      // the statistics.
      if (!init) begin
         state_d      = ST_INIT;
         rd_pending_d = 1'b0;
         vc0_wr_d     = 1'b0;
         vc1_wr_d     = 1'b0;
         vc0_count_d  = '0;
         vc1_count_d  = '0;
         error_d      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its _d input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_INIT;
         rd_pending_q <= 1'b0;
         vc_data_q    <= '0;
         vc0_wr_q     <= 1'b0;
         vc1_wr_q     <= 1'b0;
         vc0_count_q  <= '0;
         vc1_count_q  <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_pending_q <= rd_pending_d;
         vc_data_q    <= vc_data_d;
         vc0_wr_q     <= vc0_wr_d;
         vc1_wr_q     <= vc1_wr_d;
         vc0_count_q  <= vc0_count_d;
         vc1_count_q  <= vc1_count_d;
         error_q      <= error_d;
      end
   end

   assign vc_data       = vc_data_q;
   assign vc0_wr_enable = vc0_wr_q;
   assign vc1_wr_enable = vc1_wr_q;
   assign vc0_count     = vc0_count_q;
   assign vc1_count     = vc1_count_q;
   assign error         = error_q;
   assign idle          = (state_q == ST_IDLE) && !rd_pending_q && !vc0_wr_q && !vc1_wr_q;

endmodule : main_fifo_reader

// File: tb/tb_main_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_main_fifo_reader
//   Directed bench for main_fifo_reader. A queue stands in for the main FIFO;
//   every push seen on the VC side is logged with its cycle number so data,
//   routing and latency can be compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_main_fifo_reader;
   import main_fifo_reader_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic       main_empty;
   logic [5:0] main_data;
   logic       main_rd_enable;
   logic       vc0_almost_full;
   logic       vc1_almost_full;
   logic       vc0_full;
   logic       vc1_full;
   logic [5:0] vc_data;
   logic       vc0_wr_enable;
   logic       vc1_wr_enable;
   logic [7:0] vc0_count;
   logic [7:0] vc1_count;
   logic       error;
   logic       idle;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pop_count;

   logic [5:0] fifo[$];
   logic [5:0] log0[$];
   logic [5:0] log1[$];
   int         pop_cyc[$];
   int         push_cyc[$];

   always #5 clk = ~clk;

   main_fifo_reader dut (
      .clk             (clk),
      .reset           (reset),
      .init            (init),
      .main_empty      (main_empty),
      .main_data       (main_data),
      .main_rd_enable  (main_rd_enable),
      .vc0_almost_full (vc0_almost_full),
      .vc1_almost_full (vc1_almost_full),
      .vc0_full        (vc0_full),
      .vc1_full        (vc1_full),
      .vc_data         (vc_data),
      .vc0_wr_enable   (vc0_wr_enable),
      .vc1_wr_enable   (vc1_wr_enable),
      .vc0_count       (vc0_count),
      .vc1_count       (vc1_count),
      .error           (error),
      .idle            (idle)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      log0.delete();
      log1.delete();
      pop_cyc.delete();
      push_cyc.delete();
      pop_count = 0;
   endtask

   // One clock: sample the pop request before the edge, then model the main
   // FIFO read latency and log any VC push visible after the edge.
   task automatic tick();
      logic pop;
      #1;
      pop = main_rd_enable;
      if (pop) begin
         pop_count++;
         pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pop && fifo.size() > 0) main_data = fifo.pop_front();
      main_empty = (fifo.size() == 0);
      if (vc0_wr_enable) begin
         log0.push_back(vc_data);
         push_cyc.push_back(cyc);
      end
      if (vc1_wr_enable) begin
         log1.push_back(vc_data);
         push_cyc.push_back(cyc);
      end
   endtask

   initial begin
      int  guard;
      bit  checked_ff;

      reset           = 1'b0;
      init            = 1'b0;
      main_empty      = 1'b1;
      main_data       = 6'h3F;
      vc0_almost_full = 1'b0;
      vc1_almost_full = 1'b0;
      vc0_full        = 1'b0;
      vc1_full        = 1'b0;
      clear_logs();

      // ---- reset and init hold ----
      #12;
      check("rst_rd_en",   main_rd_enable, 0);
      check("rst_vc_data", vc_data, 0);
      check("rst_wr",      {vc0_wr_enable, vc1_wr_enable}, 0);
      check("rst_counts",  {vc0_count, vc1_count}, 0);
      check("rst_error",   error, 0);
      check("rst_idle",    idle, 0);
      reset = 1'b1;
      repeat (3) tick();
      check("init_hold_idle",  idle, 0);
      check("init_hold_state", dut.state_q, ST_INIT);
      check("init_hold_rd_en", main_rd_enable, 0);
      init = 1'b1;
      tick();
      check("init_release_idle",  idle, 1);
      check("init_release_state", dut.state_q, ST_IDLE);

      // ---- basic routing ----
      clear_logs();
      fifo       = '{6'h05, 6'h25, 6'h0A};
      main_empty = 1'b0;
      #1;
      check("route_pop_same_cycle", main_rd_enable, 1);
      repeat (6) tick();
      check("route_pop_count",   pop_count, 3);
      check("route_pops_b2b",    pop_cyc[2] - pop_cyc[0], 2);
      check("route_vc0_n",       log0.size(), 2);
      check("route_vc1_n",       log1.size(), 1);
      check("route_vc0_w0",      log0[0], 6'h05);
      check("route_vc1_w0",      log1[0], 6'h25);
      check("route_vc0_w1",      log0[1], 6'h0A);
      check("route_latency",     push_cyc[0] - pop_cyc[0], 2);
      check("route_pushes_b2b",  push_cyc[2] - push_cyc[0], 2);
      check("route_vc0_count",   vc0_count, 2);
      check("route_vc1_count",   vc1_count, 1);
      check("route_idle",        idle, 1);

      // ---- backpressure ----
      clear_logs();
      fifo            = '{6'h01, 6'h22};
      vc1_almost_full = 1'b1;
      main_empty      = 1'b0;
      #1;
      check("bp_rd_en_blocked", main_rd_enable, 0);
      tick();
      check("bp_state_stall", dut.state_q, ST_STALL);
      tick();
      check("bp_no_pops", pop_count, 0);
      vc1_almost_full = 1'b0;
      #1;
      check("bp_resume_same_cycle", main_rd_enable, 1);
      repeat (5) tick();
      check("bp_pop_count",  pop_count, 2);
      check("bp_vc0_n",      log0.size(), 1);
      check("bp_vc1_n",      log1.size(), 1);
      check("bp_vc0_w0",     log0[0], 6'h01);
      check("bp_vc1_w0",     log1[0], 6'h22);
      check("bp_vc0_count",  vc0_count, 3);
      check("bp_vc1_count",  vc1_count, 2);

      // ---- overflow ----
      clear_logs();
      fifo       = '{6'h11};
      main_empty = 1'b0;
      tick();
      vc0_full = 1'b1;
      tick();
      check("ovf_wr_dropped", vc0_wr_enable, 0);
      check("ovf_error",      error, 1);
      check("ovf_vc0_count",  vc0_count, 3);
      vc0_full = 1'b0;
      tick();
      check("ovf_error_sticky", error, 1);
      check("ovf_no_push",      log0.size() + log1.size(), 0);
      init = 1'b0;
      tick();
      check("ovf_init_clears_error", error, 0);
      check("ovf_init_clears_count", {vc0_count, vc1_count}, 0);
      init = 1'b1;
      tick();

      // ---- counter wrap ----
      clear_logs();
      for (int i = 0; i < 256; i++) fifo.push_back(6'(i & 31));
      main_empty = 1'b0;
      guard      = 0;
      checked_ff = 1'b0;
      while (log0.size() < 256 && guard < 400) begin
         tick();
         guard++;
         if (log0.size() == 255 && !checked_ff) begin
            check("wrap_count_ff", vc0_count, 8'hFF);
            checked_ff = 1'b1;
         end
      end
      check("wrap_done",      log0.size(), 256);
      check("wrap_count_00",  vc0_count, 8'h00);
      check("wrap_last_word", log0[255], 6'h1F);
      check("wrap_vc1_count", vc1_count, 0);
      repeat (3) tick();

      // ---- mid-operation abort ----
      clear_logs();
      fifo       = '{6'h07, 6'h27};
      main_empty = 1'b0;
      tick();
      init = 1'b0;
      repeat (4) tick();
      check("abort_pop_count", pop_count, 1);
      check("abort_no_push",   log0.size() + log1.size(), 0);
      check("abort_counts",    {vc0_count, vc1_count}, 0);
      check("abort_state",     dut.state_q, ST_INIT);
      check("abort_rd_en",     main_rd_enable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_main_fifo_reader

// File: doc/main_fifo_reader.md
Name: main_fifo_reader

Overview:
Consumer end of the main FIFO in the transmit path. It pops words from the main FIFO whenever the FIFO is non-empty and both downstream virtual-channel FIFOs (VC0, VC1) have room. It routes each popped word to VC0 or VC1 using a class bit in the word. It keeps per-VC word counters and a sticky overflow error.

Parameters:
data_width, 6, width of one FIFO word.
class_bit, 5, index of the bit that selects the VC (0 selects VC0, 1 selects VC1); must be less than data_width.
count_width, 8, width of each per-VC word counter.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
init  input  1  active-low soft hold; when 0, the block is held in INIT and counters/error are cleared synchronously.
main_empty  input  1  empty flag from the main FIFO.
main_data  input  data_width  main FIFO read data, valid one cycle after main_rd_enable.
main_rd_enable  output  1  pop request to the main FIFO.
vc0_almost_full  input  1  VC0 almost-full flag; threshold leaves at least 2 free entries.
vc1_almost_full  input  1  VC1 almost-full flag; same threshold rule as VC0.
vc0_full  input  1  VC0 full flag.
vc1_full  input  1  VC1 full flag.
vc_data  output  data_width  registered word presented to the VCs.
vc0_wr_enable  output  1  push to VC0.
vc1_wr_enable  output  1  push to VC1.
vc0_count  output  count_width  words pushed to VC0.
vc1_count  output  count_width  words pushed to VC1.
error  output  1  sticky overflow error.
idle  output  1  high in IDLE with no word in flight.

Behaviour:
- Asynchronous reset (reset=0):
  - state=INIT, rd_pending=0.
  - All outputs are 0, except main_rd_enable=0 and idle=0.
- States and transitions:
  - INIT: entered on reset or while init=0. Counters and error are cleared synchronously, no pops are issued, and any in-flight word is discarded. Leaves to IDLE on the first edge with init=1.
  - IDLE: moves to ACTIVE when main_empty=0 and both almost_full flags are 0. Moves to STALL when main_empty=0 and either almost_full flag is 1.
  - ACTIVE: moves to STALL when either almost_full flag is 1. Moves to IDLE when main_empty=1.
  - STALL: moves to ACTIVE when both almost_full flags are 0 and main_empty=0. Moves to IDLE when both almost_full flags are 0 and main_empty=1.
  - From any state, init=0 moves to INIT.
- main_rd_enable is combinational: 1 when init=1, state is not INIT, main_empty=0, vc0_almost_full=0 and vc1_almost_full=0. The gating uses the current flags, so a pop can issue in the same cycle the condition first becomes true.
- Pipeline:
  - Edge E0 (main_rd_enable=1): rd_pending is set to 1.
  - Edge E1: main_data is captured into vc_data. The write enable selected by main_data[class_bit] is set for exactly one cycle.
  - Latency from pop to VC push is 2 cycles. Back-to-back pops give one push per cycle with no bubbles.
- Both almost_full flags gate every pop because the destination is unknown at pop time. A threshold of at least 2 free entries guarantees the in-flight word fits.
- Overflow:
  - If, at E1, the target VC's full flag is 1, that write enable stays 0 and the word is dropped.
  - error is set to 1 and stays set until reset or init=0.
  - The counter for that VC is not incremented.
- Counters: increment by 1 on each asserted write enable and wrap modulo 2^count_width.
- A pop already issued completes even if the VC stalls afterwards.
- init=0 mid-operation: the pending word is dropped, both write enables are 0 on the next cycle, and counters are cleared.
- vc_data holds its last value when no write enable is asserted.
- idle = (state==IDLE) && !rd_pending && !vc0_wr_enable && !vc1_wr_enable.

Decomposition:
- Shared package holds:
  - state encodings: INIT=2'd0, IDLE=2'd1, ACTIVE=2'd2, STALL=2'd3;
  - the default data_width and class_bit.
- No sub-module. The counters are two instances of a trivial wrap counter and are inlined; the block is a single module.

Test Plan:
- Reset and init: reset=0, then reset=1 with init=0 for 3 cycles -> all outputs 0, main_rd_enable=0. Set init=1 with main_empty=1 -> idle=1 after 1 cycle.
- Basic routing: main FIFO preloaded with 6'h05, 6'h25, 6'h0A -> pops on 3 consecutive cycles. Pushes arrive 2 cycles later: vc0_wr_enable carries 6'h05, then vc1_wr_enable carries 6'h25, then vc0_wr_enable carries 6'h0A. Final counts: vc0_count=2, vc1_count=1.
- Backpressure: vc1_almost_full=1 while the FIFO is non-empty -> main_rd_enable=0 in the same cycle and the state is STALL. Release the flag -> pops resume in the same cycle with no lost or duplicated word.
- Overflow: force vc0_full=1 at the edge where 6'h11 arrives -> vc0_wr_enable=0, error=1 and sticky, vc0_count unchanged. Then init=0 -> error=0.
- Counter wrap: push 256 VC0 words -> vc0_count wraps 8'hFF to 8'h00.
- Mid-operation abort: init=0 one cycle after a pop -> no write enable pulses afterwards, counts=0, state=INIT.
